// File: rtl/bet_entry_if.sv
// ============================================================================
// Module   : bet_entry_if
// Brief    : Bet-entry bundle between the keyboard/sensor front end and the
//            bet table owner.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bet_entry_if #(
  parameter int MAX_BETS = 12
);
  logic                    rx_valid;
  logic [7:0]              rx_byte;
  logic [5:0]              bet_opcode;
  logic [2:0]              chip_color;
  logic                    round_done;
  logic [8*MAX_BETS-1:0]   bet_table;
  logic [3:0]              bet_count;
  logic                    table_full;
  logic                    spin_req;
  logic                    reject_pulse;

  modport master (
    output rx_valid, rx_byte, bet_opcode, chip_color, round_done,
    input  bet_table, bet_count, table_full, spin_req, reject_pulse
  );

  modport slave (
    input  rx_valid, rx_byte, bet_opcode, chip_color, round_done,
    output bet_table, bet_count, table_full, spin_req, reject_pulse
  );
endinterface

`default_nettype wire

// File: rtl/bet_entry_fsm.sv
// ============================================================================
// Module   : bet_entry_fsm
// Brief    : Records one roulette bet per physical keypress into a packed
//            table, raises a spin request on commit, clears on round end.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bet_entry_fsm #(
  parameter int MAX_BETS = 12
) (
  input  wire logic      clock,
  input  wire logic      reset,
  bet_entry_if.slave     bus
);

  localparam logic [7:0] C_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] C_BRK_PREFIX = 8'hF0;
  localparam logic [5:0] C_OP_NONE    = 6'b111111;
  localparam logic [5:0] C_OP_SPIN    = 6'b111110;
  localparam logic [3:0] C_MAX        = 4'(MAX_BETS);

  typedef enum logic [0:0] {
    S_OPEN   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t                r_state,      w_state_nxt;
  logic [8*MAX_BETS-1:0] r_table,      w_table_nxt;
  logic [3:0]            r_count,      w_count_nxt;
  logic                  r_full,       w_full_nxt;
  logic                  r_reject,     w_reject_nxt;
  logic                  r_brk_pend,   w_brk_pend_nxt;
  logic                  r_held_valid, w_held_valid_nxt;
  logic [7:0]            r_held_byte,  w_held_byte_nxt;

  // Byte classification, in priority order
  logic w_is_ext;
  logic w_is_brk_prefix;
  logic w_is_break;
  logic w_is_repeat;
  logic w_is_make;

  always_comb begin
    w_is_ext        = (bus.rx_byte == C_EXT_PREFIX);
    w_is_brk_prefix = !w_is_ext && (bus.rx_byte == C_BRK_PREFIX);
    w_is_break      = !w_is_ext && !w_is_brk_prefix && r_brk_pend;
    w_is_repeat     = !w_is_ext && !w_is_brk_prefix && !r_brk_pend &&
                      r_held_valid && (bus.rx_byte == r_held_byte);
    w_is_make       = !w_is_ext && !w_is_brk_prefix && !w_is_break && !w_is_repeat;
  end

  // Bet-action decode for a make code seen while the table is open
  logic w_is_spin;
  logic w_spin_ok;
  logic w_bet_bad;

  always_comb begin
    w_is_spin = (bus.bet_opcode == C_OP_SPIN);
    w_spin_ok = w_is_spin && (r_count != 4'd0);
    w_bet_bad = (bus.bet_opcode == C_OP_NONE) || (bus.chip_color == 3'b000) || r_full;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_table_nxt      = r_table;
    w_count_nxt      = r_count;
    w_reject_nxt     = 1'b0;
    w_brk_pend_nxt   = r_brk_pend;
    w_held_valid_nxt = r_held_valid;
    w_held_byte_nxt  = r_held_byte;

    if (bus.round_done) begin
      // Settlement overrides any byte arriving in the same cycle
      w_state_nxt      = S_OPEN;
      w_table_nxt      = '0;
      w_count_nxt      = 4'd0;
      w_brk_pend_nxt   = 1'b0;
      w_held_valid_nxt = 1'b0;
    end else if (bus.rx_valid) begin
      if (w_is_brk_prefix) begin
        w_brk_pend_nxt = 1'b1;
      end else if (w_is_break) begin
        w_brk_pend_nxt = 1'b0;
        if (bus.rx_byte == r_held_byte) begin
          w_held_valid_nxt = 1'b0;
        end
      end else if (w_is_make) begin
        w_held_byte_nxt  = bus.rx_byte;
        w_held_valid_nxt = 1'b1;
        if (r_state == S_OPEN) begin
          if (w_is_spin) begin
            if (w_spin_ok) begin
              w_state_nxt = S_LOCKED;
            end else begin
              w_reject_nxt = 1'b1;
            end
          end else if (w_bet_bad) begin
            w_reject_nxt = 1'b1;
          end else begin
            for (int i = 0; i < MAX_BETS; i++) begin
              if (r_count == 4'(i)) begin
                w_table_nxt[8*i +: 8] = {bus.chip_color[1:0], bus.bet_opcode};
              end
            end
            w_count_nxt = r_count + 4'd1;
          end
        end
      end
    end

    w_full_nxt = (w_count_nxt == C_MAX);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_OPEN;
      r_table      <= '0;
      r_count      <= 4'd0;
      r_full       <= 1'b0;
      r_reject     <= 1'b0;
      r_brk_pend   <= 1'b0;
      r_held_valid <= 1'b0;
      r_held_byte  <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_table      <= w_table_nxt;
      r_count      <= w_count_nxt;
      r_full       <= w_full_nxt;
      r_reject     <= w_reject_nxt;
      r_brk_pend   <= w_brk_pend_nxt;
      r_held_valid <= w_held_valid_nxt;
      r_held_byte  <= w_held_byte_nxt;
    end
  end

  assign bus.bet_table    = r_table;
  assign bus.bet_count    = r_count;
  assign bus.table_full   = r_full;
  assign bus.spin_req     = (r_state == S_LOCKED);
  assign bus.reject_pulse = r_reject;

endmodule

`default_nettype wire

// File: tb/tb_bet_entry_fsm.sv
// Directed bench for bet_entry_fsm: a behavioural model pushes the expected
// outputs of every cycle into a scoreboard that is popped after each edge.
`default_nettype none

module tb_bet_entry_fsm;

  localparam int MB = 12;

  typedef struct {
    logic [8*MB-1:0] tbl;
    logic [3:0]      count;
    logic            full;
    logic            spin;
    logic            rej;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bet_entry_if #(.MAX_BETS(MB)) bus_if ();

  bet_entry_fsm #(.MAX_BETS(MB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  logic [7:0] m_tbl [MB];
  int         m_count;
  logic       m_locked, m_brk, m_hv;
  logic [7:0] m_hb;

  task automatic chk(input string tag, input logic [8*MB-1:0] obs, input logic [8*MB-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < MB; i++) m_tbl[i] = 8'h00;
    m_count = 0;
    m_brk   = 1'b0;
    m_hv    = 1'b0;
    m_locked = 1'b0;
  endtask

  // One clock of stimulus; expected outputs are queued and checked after the edge
  task automatic step(input logic v, input logic [7:0] b, input logic [5:0] op,
                      input logic [2:0] col, input logic rd, input logic rs);
    exp_t e, got;
    logic rej;
    rej = 1'b0;
    reset             = rs;
    bus_if.rx_valid   = v;
    bus_if.rx_byte    = b;
    bus_if.bet_opcode = op;
    bus_if.chip_color = col;
    bus_if.round_done = rd;

    if (rs) begin
      model_clear();
      m_hb = 8'h00;
    end else if (rd) begin
      model_clear();
    end else if (v) begin
      if (b == 8'hE0) begin
      end else if (b == 8'hF0) begin
        m_brk = 1'b1;
      end else if (m_brk) begin
        m_brk = 1'b0;
        if (b == m_hb) m_hv = 1'b0;
      end else if (m_hv && b == m_hb) begin
      end else begin
        m_hb = b;
        m_hv = 1'b1;
        if (!m_locked) begin
          if (op == 6'b111110) begin
            if (m_count > 0) m_locked = 1'b1;
            else rej = 1'b1;
          end else if (op == 6'b111111 || col == 3'b000 || m_count == MB) begin
            rej = 1'b1;
          end else begin
            m_tbl[m_count] = {col[1:0], op};
            m_count++;
          end
        end
      end
    end

    for (int i = 0; i < MB; i++) e.tbl[8*i +: 8] = m_tbl[i];
    e.count = 4'(m_count);
    e.full  = (m_count == MB);
    e.spin  = m_locked;
    e.rej   = rej;
    sb.push_back(e);

    @(posedge clock);
    #1;
    got = sb.pop_front();
    chk("bet_table",    bus_if.bet_table,    got.tbl);
    chk("bet_count",    96'(bus_if.bet_count),    96'(got.count));
    chk("table_full",   96'(bus_if.table_full),   96'(got.full));
    chk("spin_req",     96'(bus_if.spin_req),     96'(got.spin));
    chk("reject_pulse", 96'(bus_if.reject_pulse), 96'(got.rej));
  endtask

  task automatic rx(input logic [7:0] b, input logic [5:0] op, input logic [2:0] col);
    step(1'b1, b, op, col, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 6'h3F, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic press(input logic [7:0] b, input logic [5:0] op, input logic [2:0] col);
    rx(b, op, col);
    rx(8'hF0, 6'h3F, col);
    rx(b, op, col);
  endtask

  task automatic round_done();
    step(1'b0, 8'h00, 6'h3F, 3'b000, 1'b1, 1'b0);
  endtask

  initial begin
    m_hb = 8'h00;
    model_clear();

    // Reset
    step(1'b0, 8'h00, 6'h3F, 3'b000, 1'b0, 1'b1);
    step(1'b0, 8'h00, 6'h3F, 3'b000, 1'b0, 1'b1);
    chk("reset_count", 96'(bus_if.bet_count), 96'd0);
    idle();

    // Basic bet: entry0 = {2'b10, 6'd5}
    press(8'h16, 6'd5, 3'b010);
    chk("basic_entry0", 96'(bus_if.bet_table[7:0]), 96'h85);
    chk("basic_count",  96'(bus_if.bet_count), 96'd1);
    round_done();

    // Typematic repeats must not add bets
    rx(8'h16, 6'd5, 3'b010);
    rx(8'h16, 6'd5, 3'b010);
    rx(8'h16, 6'd5, 3'b010);
    rx(8'hF0, 6'h3F, 3'b010);
    rx(8'h16, 6'd5, 3'b010);
    rx(8'h16, 6'd5, 3'b010);
    idle();
    chk("typematic_count",   96'(bus_if.bet_count), 96'd2);
    chk("typematic_entries", 96'(bus_if.bet_table[15:0]), 96'h8585);
    round_done();

    // Fill and overflow
    for (int i = 0; i < 13; i++) begin
      press(8'h20 + 8'(i), 6'(i), 3'(1 + (i % 3)));
      if (i == 11) chk("full_after_12", 96'(bus_if.table_full), 96'd1);
    end
    chk("overflow_count", 96'(bus_if.bet_count), 96'd12);
    chk("overflow_last",  96'(bus_if.bet_table[95:88]), 96'({2'b11, 6'd11}));
    round_done();

    // Rejects: no chip, no-bet opcode, spin on empty table
    press(8'h1C, 6'd7, 3'b000);
    press(8'h1B, 6'h3F, 3'b001);
    rx(8'h29, 6'h3E, 3'b001);
    chk("reject_spin", 96'(bus_if.reject_pulse), 96'd1);
    idle();
    chk("reject_count", 96'(bus_if.bet_count), 96'd0);

    // Spin and round
    press(8'h15, 6'd1, 3'b001);
    press(8'h1D, 6'd2, 3'b010);
    press(8'h24, 6'd3, 3'b011);
    rx(8'hF0, 6'h3F, 3'b011);
    rx(8'h29, 6'h3E, 3'b011);
    rx(8'h5A, 6'h3E, 3'b011);
    chk("spin_rise", 96'(bus_if.spin_req), 96'd1);
    press(8'h2D, 6'd9, 3'b001);
    idle();
    round_done();
    chk("spin_fall", 96'(bus_if.spin_req), 96'd0);
    idle();

    // Collision with round_done, then reset with break pending
    press(8'h16, 6'd5, 3'b010);
    step(1'b1, 8'h1E, 6'd6, 3'b001, 1'b1, 1'b0);
    chk("collision_count", 96'(bus_if.bet_count), 96'd0);
    rx(8'h1E, 6'd6, 3'b001);
    rx(8'hF0, 6'h3F, 3'b001);
    step(1'b0, 8'h00, 6'h3F, 3'b000, 1'b0, 1'b1);
    chk("reset_table", bus_if.bet_table, '0);
    rx(8'h1E, 6'd6, 3'b001);
    rx(8'h1E, 6'd6, 3'b001);
    idle();
    chk("post_reset_count", 96'(bus_if.bet_count), 96'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
